// File: rtl/timer_pkg.sv
// Shared constants and channel state encoding for the multi-channel timer.
package timer_pkg;

  localparam int DEF_NUM_CH       = 4;
  localparam int DEF_COUNTER_SIZE = 16;
  localparam int DEF_PRESC_WIDTH  = 8;

  localparam logic DIR_UP        = 1'b1;
  localparam logic DIR_DOWN      = 1'b0;
  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_e;

endpackage

// File: rtl/timer_channel.sv
// One timer slice: counter, run/idle state, terminal-count pulse and sticky flag.
module timer_channel
  import timer_pkg::*;
#(
  parameter int W = DEF_COUNTER_SIZE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         start,
  input  logic         stop,
  input  logic         dir,
  input  logic         oneshot,
  input  logic [W-1:0] limit,
  input  logic         ovf_clr,
  output logic [W-1:0] count,
  output logic         running,
  output logic         tc,
  output logic         ovf
);

  ch_state_e    state_r, state_s;
  logic [W-1:0] count_r, count_s, reload_s;
  logic         tc_r, tc_s, ovf_r, ovf_s;
  logic         step_s, term_s;

  // Start/stop override the tick, so a load cycle never counts.
  assign step_s   = (state_r == ST_RUN) && tick && !start && !stop;
  assign reload_s = (dir == DIR_UP) ? {W{1'b0}} : limit;
  assign term_s   = (dir == DIR_UP) ? (count_r == limit) : (count_r == {W{1'b0}});

  // State, counter and flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      count_r <= {W{1'b0}};
      tc_r    <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      tc_r    <= tc_s;
      ovf_r   <= ovf_s;
    end
  end

  // Next-state selection; stop has priority over start
  always_comb begin
    state_s = state_r;
    if (stop) begin
      state_s = ST_IDLE;
    end else if (start) begin
      state_s = ST_RUN;
    end else if (step_s && term_s && (oneshot == MODE_ONESHOT)) begin
      state_s = ST_IDLE;
    end else begin
      state_s = state_r;
    end
  end

  // Counter update, terminal pulse and sticky flag (set beats clear)
  always_comb begin
    count_s = count_r;
    tc_s    = 1'b0;
    if (stop) begin
      count_s = count_r;
    end else if (start) begin
      count_s = reload_s;
    end else if (step_s) begin
      if (term_s) begin
        tc_s = 1'b1;
        if (oneshot == MODE_ONESHOT) begin
          count_s = count_r;
        end else begin
          count_s = reload_s;
        end
      end else if (dir == DIR_UP) begin
        count_s = count_r + W'(1);
      end else begin
        count_s = count_r - W'(1);
      end
    end else begin
      count_s = count_r;
    end
    ovf_s = tc_s | (ovf_r & ~ovf_clr);
  end

  assign count   = count_r;
  assign running = (state_r == ST_RUN);
  assign tc      = tc_r;
  assign ovf     = ovf_r;

endmodule

// File: rtl/timer_multi.sv
// N-channel programmable timer with a shared tick source.
// Define TIMER_MULTI_PRESCALER_EN to divide the tick by presc_div+1.
module timer_multi
  import timer_pkg::*;
#(
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int COUNTER_SIZE = DEF_COUNTER_SIZE,
  parameter int PRESC_WIDTH  = DEF_PRESC_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [PRESC_WIDTH-1:0]         presc_div,
  input  logic [NUM_CH-1:0]              start,
  input  logic [NUM_CH-1:0]              stop,
  input  logic [NUM_CH-1:0]              dir,
  input  logic [NUM_CH-1:0]              oneshot,
  input  logic [NUM_CH*COUNTER_SIZE-1:0] limit,
  input  logic [NUM_CH-1:0]              ovf_clr,
  output logic [NUM_CH*COUNTER_SIZE-1:0] count,
  output logic [NUM_CH-1:0]              running,
  output logic [NUM_CH-1:0]              tc,
  output logic [NUM_CH-1:0]              ovf
);

  logic tick_s;

`ifdef TIMER_MULTI_PRESCALER_EN
  logic [PRESC_WIDTH-1:0] presc_r;
  logic                   presc_hit_s;

  assign presc_hit_s = (presc_r == presc_div);
  assign tick_s      = en & presc_hit_s;

  // Prescaler counts enabled cycles and wraps on the programmed divider
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r <= {PRESC_WIDTH{1'b0}};
    end else if (en) begin
      if (presc_hit_s) begin
        presc_r <= {PRESC_WIDTH{1'b0}};
      end else begin
        presc_r <= presc_r + PRESC_WIDTH'(1);
      end
    end else begin
      presc_r <= presc_r;
    end
  end
`else
  logic unused_presc_s;

  assign unused_presc_s = ^presc_div;
  assign tick_s         = en;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    timer_channel #(
      .W(COUNTER_SIZE)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .tick   (tick_s),
      .start  (start[i]),
      .stop   (stop[i]),
      .dir    (dir[i]),
      .oneshot(oneshot[i]),
      .limit  (limit[i*COUNTER_SIZE +: COUNTER_SIZE]),
      .ovf_clr(ovf_clr[i]),
      .count  (count[i*COUNTER_SIZE +: COUNTER_SIZE]),
      .running(running[i]),
      .tc     (tc[i]),
      .ovf    (ovf[i])
    );
  end

endmodule

// File: tb/tb_timer_multi.sv
// Scoreboard bench for timer_multi: the driver queues per-channel expectations,
// the negedge monitor pops and compares them against the DUT outputs.
`timescale 1ns/1ps
module tb_timer_multi;

  localparam int NCH = 4;
  localparam int W   = 16;
  localparam int PW  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [PW-1:0]     presc_div;
  logic [NCH-1:0]    start, stop, dir, oneshot, ovf_clr;
  logic [NCH*W-1:0]  limit;
  logic [NCH*W-1:0]  count;
  logic [NCH-1:0]    running, tc, ovf;

  typedef struct {
    int         cyc;
    int         ch;
    logic [W-1:0] cnt;
    logic       run;
    logic       tc;
    logic       ovf;
    string      nm;
  } exp_t;

  exp_t q[$];
  exp_t em;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  timer_multi #(.NUM_CH(NCH), .COUNTER_SIZE(W), .PRESC_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .en(en), .presc_div(presc_div),
    .start(start), .stop(stop), .dir(dir), .oneshot(oneshot),
    .limit(limit), .ovf_clr(ovf_clr),
    .count(count), .running(running), .tc(tc), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation due at this cycle
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      em = q.pop_front();
      n_checks++;
      if (em.cyc != cyc || count[em.ch*W +: W] !== em.cnt || running[em.ch] !== em.run ||
          tc[em.ch] !== em.tc || ovf[em.ch] !== em.ovf) begin
        n_fail++;
        $display("FAIL %s ch%0d cyc%0d: got count=%h running=%b tc=%b ovf=%b, expected count=%h running=%b tc=%b ovf=%b (due cyc%0d)",
                 em.nm, em.ch, cyc, count[em.ch*W +: W], running[em.ch], tc[em.ch], ovf[em.ch],
                 em.cnt, em.run, em.tc, em.ovf, em.cyc);
      end
    end
  end

  task automatic expect_ch(input int ch, input logic [W-1:0] c, input logic r,
                           input logic t, input logic o, input string nm);
    exp_t e;
    e.cyc = cyc + 1; e.ch = ch; e.cnt = c; e.run = r; e.tc = t; e.ovf = o; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pulses();
    start = '0; stop = '0; ovf_clr = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ev;
    int jj, n;
    logic tce;
    rst = 1'b1; en = 1'b1; presc_div = '0; limit = '0;
    start = '0; stop = '0; dir = '0; oneshot = '0; ovf_clr = '0;
    for (int c = 0; c < NCH; c++) expect_ch(c, 16'h0, 1'b0, 1'b0, 1'b0, "reset_init");
    step();
    step();
    rst = 1'b0;

    // Periodic up, ch0 limit=4, ovf clear and set-beats-clear collision
    limit[0*W +: W] = 16'd4; dir[0] = 1'b1; oneshot[0] = 1'b0; start[0] = 1'b1;
    expect_ch(0, 16'd0, 1'b1, 1'b0, 1'b0, "up_load");
    step(); clear_pulses();
    for (int k = 1; k <= 16; k++) begin
      ovf_clr[0] = (k == 13) || (k == 15);
      expect_ch(0, W'(k % 5), 1'b1, (k % 5 == 0), ((k >= 5 && k < 13) || k >= 15), "up_periodic");
      step();
    end
    ovf_clr = '0; stop[0] = 1'b1;
    expect_ch(0, 16'd1, 1'b0, 1'b0, 1'b1, "stop_hold");
    step(); clear_pulses();
    expect_ch(0, 16'd1, 1'b0, 1'b0, 1'b1, "idle_hold");
    step();

    // One-shot down, ch1 limit=3
    limit[1*W +: W] = 16'd3; dir[1] = 1'b0; oneshot[1] = 1'b1; start[1] = 1'b1;
    expect_ch(1, 16'd3, 1'b1, 1'b0, 1'b0, "dn_load");
    step(); clear_pulses();
    for (int k = 1; k <= 6; k++) begin
      if (k <= 3) expect_ch(1, W'(3 - k), 1'b1, 1'b0, 1'b0, "dn_count");
      else if (k == 4) expect_ch(1, 16'd0, 1'b0, 1'b1, 1'b1, "dn_tc");
      else expect_ch(1, 16'd0, 1'b0, 1'b0, 1'b1, "dn_hold");
      step();
    end

    // start+stop in the same cycle keeps ch3 idle with no load
    limit[3*W +: W] = 16'd7; dir[3] = 1'b0; start[3] = 1'b1; stop[3] = 1'b1;
    expect_ch(3, 16'd0, 1'b0, 1'b0, 1'b0, "start_stop");
    step(); clear_pulses();
    expect_ch(3, 16'd0, 1'b0, 1'b0, 1'b0, "start_stop_idle");
    step();

    // limit=0: terminal on every tick
    limit[3*W +: W] = 16'd0; dir[3] = 1'b1; oneshot[3] = 1'b0; start[3] = 1'b1;
    expect_ch(3, 16'd0, 1'b1, 1'b0, 1'b0, "lim0_load");
    step(); clear_pulses();
    for (int k = 1; k <= 4; k++) begin
      expect_ch(3, 16'd0, 1'b1, 1'b1, 1'b1, "lim0_tc");
      step();
    end
    stop[3] = 1'b1;
    expect_ch(3, 16'd0, 1'b0, 1'b0, 1'b1, "lim0_stop");
    step(); clear_pulses();

    // Independence: ch0 periodic up limit=2, ch2 one-shot down limit=5
    limit[0*W +: W] = 16'd2; dir[0] = 1'b1; oneshot[0] = 1'b0;
    limit[2*W +: W] = 16'd5; dir[2] = 1'b0; oneshot[2] = 1'b1;
    start[0] = 1'b1; start[2] = 1'b1; ovf_clr[0] = 1'b1;
    expect_ch(0, 16'd0, 1'b1, 1'b0, 1'b0, "ind0_load");
    expect_ch(2, 16'd5, 1'b1, 1'b0, 1'b0, "ind2_load");
    step(); clear_pulses();
    for (int k = 1; k <= 8; k++) begin
      expect_ch(0, W'(k % 3), 1'b1, (k % 3 == 0), (k >= 3), "ind0");
      if (k <= 5) expect_ch(2, W'(5 - k), 1'b1, 1'b0, 1'b0, "ind2");
      else if (k == 6) expect_ch(2, 16'd0, 1'b0, 1'b1, 1'b1, "ind2_tc");
      else expect_ch(2, 16'd0, 1'b0, 1'b0, 1'b1, "ind2_hold");
      if (k == 1) expect_ch(1, 16'd0, 1'b0, 1'b0, 1'b1, "ind1_quiet");
      step();
    end
    stop[0] = 1'b1;
    expect_ch(0, 16'd2, 1'b0, 1'b0, 1'b1, "ind0_stop");
    step(); clear_pulses();

    // Wrap: load 0xFFF0 counting down, then count up past 0xFFFF with limit 0x0010
    dir[0] = 1'b0; oneshot[0] = 1'b0; limit[0*W +: W] = 16'hFFF0; start[0] = 1'b1; ovf_clr[0] = 1'b1;
    expect_ch(0, 16'hFFF0, 1'b1, 1'b0, 1'b0, "wrap_load");
    step(); clear_pulses();
    dir[0] = 1'b1; limit[0*W +: W] = 16'h0010;
    for (int k = 1; k <= 35; k++) begin
      ev = 16'hFFF0 + W'(k);
      if (k <= 32) expect_ch(0, ev, 1'b1, 1'b0, 1'b0, "wrap_cnt");
      else if (k == 33) expect_ch(0, 16'd0, 1'b1, 1'b1, 1'b1, "wrap_tc");
      else expect_ch(0, W'(k - 33), 1'b1, 1'b0, 1'b1, "wrap_post");
      step();
    end

    // en low freezes the running channel
    en = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      expect_ch(0, 16'd2, 1'b1, 1'b0, 1'b1, "en_freeze");
      step();
    end
    en = 1'b1;
    expect_ch(0, 16'd3, 1'b1, 1'b0, 1'b1, "en_resume");
    step();

`ifdef TIMER_MULTI_PRESCALER_EN
    // Prescaler: presc_div=2, limit=1 up periodic, with an en=0 window
    stop[0] = 1'b1;
    expect_ch(0, 16'd3, 1'b0, 1'b0, 1'b1, "pre_stop");
    step(); clear_pulses();
    presc_div = 8'd2; limit[0*W +: W] = 16'd1; dir[0] = 1'b1; oneshot[0] = 1'b0;
    start[0] = 1'b1; ovf_clr[0] = 1'b1;
    expect_ch(0, 16'd0, 1'b1, 1'b0, 1'b0, "presc_load");
    step(); clear_pulses();
    for (int j = 1; j <= 20; j++) begin
      en = !(j >= 13 && j <= 16);
      jj = (j > 16) ? (j - 4) : ((j >= 13) ? 12 : j);
      n = (jj + 1) / 3;
      tce = (j < 13 || j > 16) && (jj % 3 == 2) && (n % 2 == 0);
      expect_ch(0, W'(n % 2), 1'b1, tce, (jj >= 5), "presc");
      step();
    end
    en = 1'b1;
`endif

    // Reset mid-run aborts every channel
    limit[2*W +: W] = 16'd9; dir[2] = 1'b1; oneshot[2] = 1'b0; start[2] = 1'b1;
    expect_ch(2, 16'd0, 1'b1, 1'b0, 1'b1, "pre_rst_load");
    step(); clear_pulses();
    rst = 1'b1; presc_div = '0;
    for (int r = 1; r <= 3; r++) begin
      for (int c = 0; c < NCH; c++) expect_ch(c, 16'd0, 1'b0, 1'b0, 1'b0, "rst_mid");
      step();
    end
    rst = 1'b0;
    for (int r = 1; r <= 2; r++) begin
      for (int c = 0; c < NCH; c++) expect_ch(c, 16'd0, 1'b0, 1'b0, 1'b0, "rst_idle");
      step();
    end

    @(negedge clk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
